// File: rtl/adder_share_ctrl.sv
// Shares one registered adder among NREQ requesters: arbitration, operand staging, tag pipe and result return.
// Optional macro ARB_ROUND_ROBIN_EN selects round-robin arbitration; default build is fixed priority.
module adder_share_ctrl #(
  parameter int unsigned N       = 16,
  parameter int unsigned NREQ    = 4,
  parameter int unsigned ADD_LAT = 1
) (
  input  logic                 clock,
  input  logic                 i_reset,
  input  logic                 i_enable,
  input  logic [NREQ-1:0]      i_req,
  input  logic [NREQ*N-1:0]    i_a,
  input  logic [NREQ*N-1:0]    i_b,
  input  logic [NREQ-1:0]      i_cin,
  output logic [NREQ-1:0]      o_gnt,
  output logic [N-1:0]         o_add_a,
  output logic [N-1:0]         o_add_b,
  output logic                 o_add_cin,
  input  logic [N:0]           i_add_sum,
  output logic [NREQ-1:0]      o_rsp_valid,
  output logic [N:0]           o_rsp_sum,
  output logic                 o_busy
);
  localparam int unsigned IDW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                      state;
  state_t                      state_nx;
  logic                        gnt_en;
  logic                        gnt_any;
  logic [IDW-1:0]              gnt_id;
  logic [NREQ-1:0][N-1:0]      a_lanes;
  logic [NREQ-1:0][N-1:0]      b_lanes;
  logic [ADD_LAT:0]            tag_vld;
  logic [ADD_LAT:0]            tag_vld_nx;
  logic [ADD_LAT:0][IDW-1:0]   tag_id;

  assign a_lanes    = i_a;
  assign b_lanes    = i_b;
  assign tag_vld_nx = {tag_vld[ADD_LAT-1:0], gnt_any};
  assign o_gnt      = gnt_any ? (NREQ'(1) << gnt_id) : '0;

  // state register
  always_ff @(posedge clock) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nx;
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (i_enable) state_nx = RUN;
      RUN:     if (!i_enable) state_nx = DRAIN;
      DRAIN: begin
        if (i_enable)      state_nx = RUN;
        else if (~|tag_vld) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // grants are allowed in RUN, and in DRAIN when it is returning to RUN this cycle
  always_comb begin
    gnt_en = 1'b0;
    if (i_enable && (state == RUN || state == DRAIN)) gnt_en = 1'b1;
  end

`ifdef ARB_ROUND_ROBIN_EN
  logic [IDW-1:0] ptr;
  logic [IDW:0]   rr_idx;

  // search starts one past the last granted requester
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    rr_idx  = '0;
    for (int i = 1; i <= int'(NREQ); i++) begin
      rr_idx = {1'b0, ptr} + (IDW+1)'(i);
      if (rr_idx >= (IDW+1)'(NREQ)) rr_idx = rr_idx - (IDW+1)'(NREQ);
      if (gnt_en && !gnt_any && i_req[rr_idx[IDW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_id  = rr_idx[IDW-1:0];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (i_reset)      ptr <= IDW'(NREQ - 1);
    else if (gnt_any) ptr <= gnt_id;
  end
`else
  // fixed priority, lowest index wins
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      if (gnt_en && i_req[i]) begin
        gnt_any = 1'b1;
        gnt_id  = IDW'(i);
      end
    end
  end
`endif

  // operand staging toward the shared adder
  always_ff @(posedge clock) begin
    if (i_reset) begin
      o_add_a   <= '0;
      o_add_b   <= '0;
      o_add_cin <= 1'b0;
    end else if (gnt_any) begin
      o_add_a   <= a_lanes[gnt_id];
      o_add_b   <= b_lanes[gnt_id];
      o_add_cin <= i_cin[gnt_id];
    end
  end

  // tag pipe aligned so the last stage coincides with a valid adder result
  always_ff @(posedge clock) begin
    if (i_reset) begin
      tag_vld <= '0;
      tag_id  <= '0;
    end else begin
      tag_vld <= tag_vld_nx;
      tag_id  <= {tag_id[ADD_LAT-1:0], gnt_id};
    end
  end

  always_ff @(posedge clock) begin
    if (i_reset) begin
      o_rsp_valid <= '0;
      o_rsp_sum   <= '0;
      o_busy      <= 1'b0;
    end else begin
      o_rsp_valid <= tag_vld[ADD_LAT] ? (NREQ'(1) << tag_id[ADD_LAT]) : '0;
      if (tag_vld[ADD_LAT]) o_rsp_sum <= i_add_sum;
      o_busy      <= (state_nx != IDLE) || (|tag_vld_nx);
    end
  end

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Randomized self-checking bench for adder_share_ctrl against a queue-based transaction model.
module tb_adder_share_ctrl;
  localparam int N       = 16;
  localparam int NREQ    = 4;
  localparam int ADD_LAT = 1;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_DRAIN = 2;

  logic              clock = 1'b0;
  logic              i_reset, i_enable;
  logic [NREQ-1:0]   i_req, i_cin;
  logic [NREQ*N-1:0] i_a, i_b;
  logic [NREQ-1:0]   o_gnt, o_rsp_valid;
  logic [N-1:0]      o_add_a, o_add_b;
  logic              o_add_cin, o_busy;
  logic [N:0]        i_add_sum, o_rsp_sum;

  adder_share_ctrl #(.N(N), .NREQ(NREQ), .ADD_LAT(ADD_LAT)) dut (
    .clock(clock), .i_reset(i_reset), .i_enable(i_enable), .i_req(i_req),
    .i_a(i_a), .i_b(i_b), .i_cin(i_cin), .o_gnt(o_gnt),
    .o_add_a(o_add_a), .o_add_b(o_add_b), .o_add_cin(o_add_cin),
    .i_add_sum(i_add_sum), .o_rsp_valid(o_rsp_valid), .o_rsp_sum(o_rsp_sum),
    .o_busy(o_busy)
  );

  always #5 clock = ~clock;

  // external adder with one edge of latency
  always @(posedge clock) i_add_sum <= (N+1)'(o_add_a) + (N+1)'(o_add_b) + (N+1)'(o_add_cin);

  typedef struct { int id; logic [N:0] sum; int due; } op_t;
  op_t sbq[$];

  int total = 0, bad = 0, cyc = 0;
  int m_state = M_IDLE, m_ptr = NREQ - 1;
  logic [N-1:0]    m_add_a = '0, m_add_b = '0;
  logic            m_add_cin = 1'b0;
  logic [NREQ-1:0] exp_gnt, obs_gnt, exp_rv, obs_rv;
  logic [N:0]      exp_rs, obs_rs;
  logic            exp_busy, obs_busy, obs_add_cin;
  logic [N-1:0]    obs_add_a, obs_add_b;

  // drive-side model step: predict the grant, then advance one clock and predict registered outputs
  task automatic step();
    int gid;
    op_t op;
    #1;
    obs_gnt = o_gnt;
    gid = -1;
    if (i_enable && m_state != M_IDLE) begin
`ifdef ARB_ROUND_ROBIN_EN
      for (int i = 1; i <= NREQ; i++)
        if (gid < 0 && i_req[(m_ptr + i) % NREQ]) gid = (m_ptr + i) % NREQ;
`else
      for (int i = 0; i < NREQ; i++)
        if (gid < 0 && i_req[i]) gid = i;
`endif
    end
    exp_gnt = (gid < 0) ? '0 : (NREQ'(1) << gid);
    if (i_reset) begin
      sbq.delete();
      m_state = M_IDLE; m_ptr = NREQ - 1;
      m_add_a = '0; m_add_b = '0; m_add_cin = 1'b0;
    end else begin
      if (gid >= 0) begin
        op.id  = gid;
        op.sum = (N+1)'(i_a[gid*N +: N]) + (N+1)'(i_b[gid*N +: N]) + (N+1)'(i_cin[gid]);
        op.due = cyc + ADD_LAT + 2;
        sbq.push_back(op);
        m_add_a = i_a[gid*N +: N]; m_add_b = i_b[gid*N +: N]; m_add_cin = i_cin[gid];
        m_ptr = gid;
      end
      case (m_state)
        M_IDLE:  if (i_enable) m_state = M_RUN;
        M_RUN:   if (!i_enable) m_state = M_DRAIN;
        default: if (i_enable) m_state = M_RUN; else if (sbq.size() == 0) m_state = M_IDLE;
      endcase
    end
    @(posedge clock); #1;
    cyc++;
    obs_rv = o_rsp_valid; obs_rs = o_rsp_sum; obs_busy = o_busy;
    obs_add_a = o_add_a; obs_add_b = o_add_b; obs_add_cin = o_add_cin;
    exp_rv = '0;
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      exp_rv = NREQ'(1) << sbq[0].id;
      exp_rs = sbq[0].sum;
      void'(sbq.pop_front());
    end
    exp_busy = (m_state != M_IDLE) || (sbq.size() > 0);
  endtask

  task automatic rand_ops();
    i_a = {$urandom(), $urandom()};
    i_b = {$urandom(), $urandom()};
    i_cin = NREQ'($urandom());
  endtask

  task automatic test_reset();
    i_reset = 1'b1; i_enable = 1'b1; i_req = '1; rand_ops();
    for (int c = 0; c < 3; c++) begin
      step();
      total++; if (obs_gnt !== '0) begin bad++; $display("FAIL reset_gnt c%0d got %b want 0", c, obs_gnt); end
      total++; if (obs_rv !== '0) begin bad++; $display("FAIL reset_rv c%0d got %b want 0", c, obs_rv); end
      total++; if ({obs_add_a, obs_add_b, obs_add_cin} !== '0)
        begin bad++; $display("FAIL reset_add c%0d got %h/%h/%b want 0", c, obs_add_a, obs_add_b, obs_add_cin); end
      total++; if (obs_busy !== 1'b0) begin bad++; $display("FAIL reset_busy c%0d got %b want 0", c, obs_busy); end
      total++; if (obs_rs !== '0) begin bad++; $display("FAIL reset_sum c%0d got %h want 0", c, obs_rs); end
    end
    i_reset = 1'b0; i_req = '0;
  endtask

  task automatic test_single_op();
    i_enable = 1'b1; i_req = '0;
    step();
    i_a[2*N +: N] = 16'hFFFF; i_b[2*N +: N] = 16'h0001; i_cin = 4'b0100; i_req = 4'b0100;
    step();
    total++; if (obs_gnt !== 4'b0100) begin bad++; $display("FAIL single_gnt got %b want 0100", obs_gnt); end
    i_req = '0;
    for (int c = 1; c <= 5; c++) begin
      if (c > 1) step();
      total++;
      if (c == 3) begin
        if (obs_rv !== 4'b0100 || obs_rs !== 17'h10001) begin
          bad++; $display("FAIL single_rsp got %b/%h want 0100/10001", obs_rv, obs_rs);
        end
      end else if (obs_rv !== '0) begin
        bad++; $display("FAIL single_quiet c%0d got %b want 0", c, obs_rv);
      end
    end
  endtask

  task automatic test_contention();
    logic [NREQ-1:0] want;
    i_reset = 1'b1; i_req = '0; step();
    i_reset = 1'b0; i_enable = 1'b1; step();
    for (int c = 0; c < 14; c++) begin
      i_req = (c < 8) ? '1 : '0;
      rand_ops();
      step();
`ifdef ARB_ROUND_ROBIN_EN
      want = (c < 8) ? (NREQ'(1) << (c % NREQ)) : '0;
`else
      want = (c < 8) ? NREQ'(1) : '0;
`endif
      total++; if (obs_gnt !== want) begin bad++; $display("FAIL cont_gnt c%0d got %b want %b", c, obs_gnt, want); end
      total++; if (obs_gnt !== exp_gnt) begin bad++; $display("FAIL cont_gnt_model c%0d got %b want %b", c, obs_gnt, exp_gnt); end
      total++; if (obs_rv !== exp_rv) begin bad++; $display("FAIL cont_rv c%0d got %b want %b", c, obs_rv, exp_rv); end
      if (exp_rv != '0) begin
        total++; if (obs_rs !== exp_rs) begin bad++; $display("FAIL cont_sum c%0d got %h want %h", c, obs_rs, exp_rs); end
      end
    end
  endtask

  task automatic test_drain();
    int nresp = 0;
    i_enable = 1'b1; i_req = '1;
    for (int c = 0; c < 10; c++) begin
      rand_ops();
      if (c == 4) i_enable = 1'b0;
      step();
      if (c < 4) begin
        total++; if (obs_gnt === '0) begin bad++; $display("FAIL drain_grant c%0d got 0 want onehot", c); end
      end else begin
        total++; if (obs_gnt !== '0) begin bad++; $display("FAIL drain_nogrant c%0d got %b want 0", c, obs_gnt); end
      end
      if (obs_rv != '0) nresp++;
      total++; if (obs_rv !== exp_rv) begin bad++; $display("FAIL drain_rv c%0d got %b want %b", c, obs_rv, exp_rv); end
      if (exp_rv != '0) begin
        total++; if (obs_rs !== exp_rs) begin bad++; $display("FAIL drain_sum c%0d got %h want %h", c, obs_rs, exp_rs); end
      end
      total++; if (obs_busy !== exp_busy) begin bad++; $display("FAIL drain_busy c%0d got %b want %b", c, obs_busy, exp_busy); end
    end
    total++; if (nresp != 4) begin bad++; $display("FAIL drain_count got %0d want 4", nresp); end
    total++; if (obs_busy !== 1'b0) begin bad++; $display("FAIL drain_idle got %b want 0", obs_busy); end
    i_req = '0;
  endtask

  task automatic test_reset_midflight();
    i_enable = 1'b1; i_req = '0; step();
    i_req = '1;
    for (int c = 0; c < 3; c++) begin rand_ops(); step(); end
    i_req = '0; i_reset = 1'b1; step();
    i_reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      total++; if (obs_rv !== '0) begin bad++; $display("FAIL midrst_quiet c%0d got %b want 0", c, obs_rv); end
    end
    rand_ops(); i_req = 4'b0010;
    for (int c = 1; c <= 5; c++) begin
      step();
      if (c == 1) begin
        total++; if (obs_gnt !== 4'b0010) begin bad++; $display("FAIL midrst_gnt got %b want 0010", obs_gnt); end
        i_req = '0;
      end
      total++;
      if (obs_rv !== ((c == ADD_LAT + 2) ? 4'b0010 : 4'b0000)) begin
        bad++; $display("FAIL midrst_rsp c%0d got %b", c, obs_rv);
      end
      if (exp_rv != '0) begin
        total++; if (obs_rs !== exp_rs) begin bad++; $display("FAIL midrst_sum got %h want %h", obs_rs, exp_rs); end
      end
    end
  endtask

  task automatic test_wrap();
    i_enable = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      i_req = '0;
      if (c == 1) begin i_a[3*N +: N] = 16'h8000; i_b[3*N +: N] = 16'h8000; i_cin = 4'b0000; i_req = 4'b1000; end
      if (c == 2) begin i_a[0 +: N] = 16'h0000; i_b[0 +: N] = 16'h0000; i_cin = 4'b0001; i_req = 4'b0001; end
      step();
      total++;
      if (c == 3) begin
        if (obs_rv !== 4'b1000 || obs_rs !== 17'h10000) begin bad++; $display("FAIL wrap_msb got %b/%h want 1000/10000", obs_rv, obs_rs); end
      end else if (c == 4) begin
        if (obs_rv !== 4'b0001 || obs_rs !== 17'h00001) begin bad++; $display("FAIL wrap_cin got %b/%h want 0001/00001", obs_rv, obs_rs); end
      end else if (obs_rv !== '0) begin
        bad++; $display("FAIL wrap_quiet c%0d got %b want 0", c, obs_rv);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      i_reset  = (c < 390) && ($urandom_range(0, 99) == 0);
      i_enable = (c < 390) && ($urandom_range(0, 9) != 0);
      i_req    = NREQ'($urandom());
      rand_ops();
      step();
      total++; if (obs_gnt !== exp_gnt) begin bad++; $display("FAIL rnd_gnt c%0d got %b want %b", c, obs_gnt, exp_gnt); end
      total++; if (obs_rv !== exp_rv) begin bad++; $display("FAIL rnd_rv c%0d got %b want %b", c, obs_rv, exp_rv); end
      if (exp_rv != '0) begin
        total++; if (obs_rs !== exp_rs) begin bad++; $display("FAIL rnd_sum c%0d got %h want %h", c, obs_rs, exp_rs); end
      end
      total++; if (obs_busy !== exp_busy) begin bad++; $display("FAIL rnd_busy c%0d got %b want %b", c, obs_busy, exp_busy); end
      total++;
      if ({obs_add_a, obs_add_b, obs_add_cin} !== {m_add_a, m_add_b, m_add_cin}) begin
        bad++; $display("FAIL rnd_add c%0d got %h/%h/%b want %h/%h/%b", c, obs_add_a, obs_add_b, obs_add_cin, m_add_a, m_add_b, m_add_cin);
      end
    end
    i_reset = 1'b0; i_enable = 1'b0; i_req = '0;
  endtask

  initial begin
    i_reset = 1'b1; i_enable = 1'b0; i_req = '0; i_cin = '0; i_a = '0; i_b = '0;
    step(); step();
    test_reset();
    test_single_op();
    test_contention();
    test_drain();
    test_reset_midflight();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
